// File: rtl/pumpen_steuerung_n.sv
// Pump-station controller: thermometer level sensors in, pump enables out, with
// count hysteresis, dwell time between count changes, lead rotation and fail-safe fault mode.
module pumpen_steuerung_n #(
  parameter int unsigned N_PUMPS   = 2,
  parameter int unsigned MIN_DWELL = 4,
  parameter int unsigned FAULT_CLR = 3,
  parameter int unsigned ROTATE    = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [N_PUMPS:0]                               x,
  output logic [N_PUMPS-1:0]                             y,
  output logic [$clog2(N_PUMPS+1)-1:0]                   active_cnt,
  output logic [((N_PUMPS > 1) ? $clog2(N_PUMPS) : 1)-1:0] lead,
  output logic                                           fault
);

  localparam int unsigned AW  = $clog2(N_PUMPS + 1);
  localparam int unsigned LW  = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1;
  localparam int unsigned LCW = $clog2(N_PUMPS + 2);
  localparam int unsigned DW  = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam int unsigned CW  = $clog2(FAULT_CLR + 1);

  localparam logic [DW-1:0] DWELL_RLD = DW'(MIN_DWELL - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(FAULT_CLR - 1);
  localparam logic [AW-1:0] A_MAX     = AW'(N_PUMPS);
  localparam logic [LW-1:0] LEAD_LAST = LW'(N_PUMPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       a_q, a_d;
  logic [LW-1:0]       lead_q, lead_d;
  logic [N_PUMPS-1:0]  y_q, y_d;
  logic                fault_q, fault_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [CW-1:0]       clr_q, clr_d;

  logic [N_PUMPS:0]    x_inc;
  logic                valid;
  logic [LCW-1:0]      lvl;
  logic [LCW-1:0]      a_ext;

  // Pump j is on when its distance behind the lead pump is below the demanded count.
  function automatic logic [N_PUMPS-1:0] pump_map(input logic [AW-1:0] a,
                                                  input logic [LW-1:0] ld);
    logic [N_PUMPS-1:0] m;
    int unsigned        off;
    m = '0;
    for (int unsigned j = 0; j < N_PUMPS; j++) begin
      off = (j + N_PUMPS - 32'(ld)) % N_PUMPS;
      if (off < 32'(a)) m[j] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    x_inc = x + (N_PUMPS + 1)'(1);
    valid = ((x & x_inc) == '0);
    lvl   = '0;
    for (int unsigned i = 0; i <= N_PUMPS; i++) lvl = lvl + LCW'(x[i]);
    a_ext = LCW'(a_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    lead_d  = lead_q;
    fault_d = fault_q;
    clr_d   = clr_q;
    dwell_d = (dwell_q != '0) ? dwell_q - 1'b1 : dwell_q;

    if (!valid) begin
      state_d = FAULT;
      fault_d = 1'b1;
      a_d     = A_MAX;
      clr_d   = '0;
    end else if (state_q == FAULT) begin
      if (clr_q == CLR_LAST) begin
        a_d     = (lvl > LCW'(N_PUMPS)) ? A_MAX : AW'(lvl);
        state_d = (a_d == '0) ? IDLE : RUN;
        fault_d = 1'b0;
        dwell_d = DWELL_RLD;
        clr_d   = '0;
      end else begin
        clr_d = clr_q + 1'b1;
      end
    end else if (dwell_q == '0) begin
      if ((lvl > a_ext) && (a_q < A_MAX)) begin
        a_d     = a_q + 1'b1;
        dwell_d = DWELL_RLD;
      end else if ((a_q != '0) && ((lvl == '0) || (lvl < a_ext - 1'b1))) begin
        a_d     = a_q - 1'b1;
        dwell_d = DWELL_RLD;
        if ((ROTATE != 0) && (N_PUMPS > 1) && (a_q == AW'(1)))
          lead_d = (lead_q == LEAD_LAST) ? '0 : lead_q + 1'b1;
      end
      state_d = (a_d == '0) ? IDLE : RUN;
    end

    y_d = fault_d ? '1 : pump_map(a_d, lead_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      lead_q  <= '0;
      y_q     <= '0;
      fault_q <= 1'b0;
      dwell_q <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      lead_q  <= lead_d;
      y_q     <= y_d;
      fault_q <= fault_d;
      dwell_q <= dwell_d;
      clr_q   <= clr_d;
    end
  end

  assign y          = y_q;
  assign active_cnt = a_q;
  assign lead       = lead_q;
  assign fault      = fault_q;

endmodule

// File: doc/pumpen_steuerung_n.md
Name: pumpen_steuerung_n

Overview:
Parametrised pump-station controller and successor of the fixed two-pump automaton. It reads a thermometer-coded bank of N_PUMPS+1 level sensors and drives N_PUMPS pump enables. Over the fixed automaton it adds:
- hysteresis on pump count
- a minimum dwell time between changes
- lead-pump rotation for wear levelling
- a fail-safe fault mode for implausible sensor codes

It sits between the synchronised sensor inputs and the pump driver outputs.

Parameters:
N_PUMPS, 2, number of pumps (>=1); sensor width is N_PUMPS+1.
MIN_DWELL, 4, minimum clocks between two changes of active pump count (>=1).
FAULT_CLR, 3, consecutive valid sensor samples needed to leave FAULT (>=1).
ROTATE, 1, 1 = advance lead pump after each pump-down-to-zero; 0 = lead fixed at pump 0.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
x  in  N_PUMPS+1  level sensors, x[0] lowest mark, thermometer code (1 = wet)
y  out  N_PUMPS  pump enables, registered, 1 = pump on
active_cnt  out  clog2(N_PUMPS+1)  number of pumps currently demanded (A)
lead  out  max(1,clog2(N_PUMPS))  index of lead pump
fault  out  1  high while in FAULT state

Behaviour:
- Reset (rst_n low, asynchronous): the following registers clear immediately and hold until the first edge after release:
  - state = IDLE, A = 0, y = 0, lead = 0, fault = 0
  - dwell_cnt = 0, so the first change is allowed at once
  - clr_cnt = 0
- Validity: x is valid iff it is a thermometer code (all ones below the highest one; 0 allowed). L = popcount(x) when valid.
- States: IDLE (A=0), RUN (A>0), FAULT. One decision per rising edge; all outputs are registered. A sensor change sampled at edge t appears on y/active_cnt after edge t (1-clock latency).
- Fault entry:
  - Applies from any state, has priority over everything, and ignores dwell.
  - Invalid x sampled → FAULT.
  - In FAULT: fault = 1, y = all ones (fail-safe against overflow), active_cnt = N_PUMPS, lead frozen.
- FAULT exit:
  - clr_cnt counts consecutive valid samples and resets to 0 on any invalid sample.
  - When the count reaches FAULT_CLR, on that edge: A = min(L, N_PUMPS), state = IDLE if A=0 else RUN, fault = 0, dwell_cnt = MIN_DWELL-1, clr_cnt = 0.
- Hysteresis (IDLE/RUN, valid x, dwell_cnt == 0):
  - Up when L > A and A < N_PUMPS: A <= A+1.
  - Down when L == 0 or L+1 < A: A <= A-1.
  - Otherwise A holds. Example: A=2, L=1 holds.
  - A changes by at most 1 per step.
- Dwell:
  - Every change of A loads dwell_cnt = MIN_DWELL-1.
  - dwell_cnt decrements by 1 per clock while > 0.
  - Changes are blocked while dwell_cnt != 0; blocked demands persist and act when dwell expires.
- Rotation: if ROTATE=1, on the edge where A goes 1→0, lead <= (lead+1) mod N_PUMPS. Lead does not change at any other time.
- Output mapping: y[(lead+i) mod N_PUMPS] = 1 for i = 0..A-1; all other bits 0. Pumps are added and removed in that order, so the lead pump is the first on and the last off.
- N_PUMPS=1: lead is constant 0 and rotation has no effect.
- x must be synchronised externally; the block adds no synchroniser.

Test Plan:
1. Reset then staircase. N=2, DWELL=4. x=000→001: at the next edge A=1, y=01. Hold 001 for 10 clocks: y stays 01. x=011: A=2, y=11 on the first allowed edge.
2. Dwell blocking. From A=0, apply x=111 at once: A=1 at edge t, A=2 exactly at edge t+4, never earlier. Drop to x=000 at t+5: A=1 at t+8, A=0 at t+12.
3. Hysteresis. From A=2, x=001: A holds at 2 (L+1 = A). Then x=000: A steps down to 1, then to 0.
4. Rotation. Complete cycle 000→001→000: lead 0→1. Next x=001 gives y=10. Second cycle: lead returns to 0. With ROTATE=0, lead stays 0 throughout.
5. Fault. From A=1 (y=01), x=010: y=11 and fault=1 at the next edge even mid-dwell. Send 2 valid samples, then 101: clr_cnt restarts. Then 3 valid samples of 011: fault=0, A=2, y=11, dwell reloaded.
6. Async reset mid-RUN. Assert rst_n between edges: y=0, fault=0, lead=0 immediately. Release with x=001: A=1 at the first edge after release.
